usb_fifo_loop: RTL
==================

USB_FIFO_LOOP -- requirements
Module: usb_fifo_loop

Interface
REQ-001 Parameter DW, default 16, width of FD and the buffer words; legal values 8 or 16.
REQ-002 Parameter DEPTH, default 256, number of buffer words; power of two, 4..1024; AW = log2(DEPTH).
REQ-003 CLKOUT  input  1  single clock for all logic; all state changes on the CLKOUT rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 FLAGA  input  1  EP2 OUT FIFO not-empty flag; 1 = data available.
REQ-006 FLAGD  input  1  EP6 IN FIFO not-full flag; 1 = space available.
REQ-007 SLRD  output  1  read strobe, active-low.
REQ-008 SLWR  output  1  write strobe, active-low.
REQ-009 SLOE  output  1  FD output enable toward the FX2, active-low.
REQ-010 PKTEND  output  1  packet commit strobe, active-low.
REQ-011 IFCLK  output  1  equals ~CLKOUT at all times, including during reset.
REQ-012 FIFOADR  output  2  endpoint select: 00 = EP2, 10 = EP6.
REQ-013 FD  inout  DW  FX2 data bus.
REQ-014 word_cnt  output  AW+1  current buffer occupancy.
REQ-015 pkt_count  output  16  number of completed loop-back bursts, wraps at 0xFFFF to 0.

Function
REQ-016 The states SHALL be IDLE, SEL_RD, READ, SEL_WR, WRITE and COMMIT.
REQ-017 IDLE -> SEL_RD when FLAGA=1; otherwise the FSM stays in IDLE.
REQ-018 SEL_RD lasts one cycle with FIFOADR=00 and SLOE=0, then goes to READ.
REQ-019 In READ: SLOE=0; SLRD=0 in any cycle with FLAGA=1 and word_cnt<DEPTH; FD is sampled into the buffer tail on the same rising edge.
REQ-020 READ -> SEL_WR when FLAGA=0 or word_cnt reaches DEPTH; if word_cnt=0 at that point, READ -> IDLE instead.
REQ-021 SEL_WR lasts one cycle with FIFOADR=10, SLOE=1 and FD undriven (bus turnaround), then goes to WRITE.
REQ-022 In WRITE: FD is driven with the buffer head word; SLWR=0 in any cycle with FLAGD=1 and word_cnt>0; the head advances on that edge.
REQ-023 FLAGD=0 in WRITE SHALL stall: SLWR=1 and FD holds the same word.
REQ-024 WRITE -> COMMIT on the edge that writes the last buffered word.
REQ-025 COMMIT lasts one cycle, increments pkt_count, then goes to IDLE.
REQ-026 Buffer order SHALL be strict FIFO; head and tail pointers wrap modulo DEPTH.
REQ-027 FD SHALL be driven only in WRITE and COMMIT, and is high-Z in every other state.
REQ-028 FIFOADR SHALL be 00 in IDLE, SEL_RD and READ, and 10 in SEL_WR, WRITE and COMMIT.
REQ-029 SLRD and SLWR SHALL never be low in the same cycle.
REQ-030 A burst longer than DEPTH SHALL be handled as a DEPTH-word loop followed by a new loop for the remainder.

Reset
REQ-031 While rst_n=0 the block SHALL be in IDLE with SLRD=SLWR=SLOE=PKTEND=1, FIFOADR=00, FD high-Z, word_cnt=0, pkt_count=0 and both pointers at 0.
REQ-032 Reset asserted mid-READ or mid-WRITE SHALL discard buffered data immediately, with no strobe asserted after the reset edge.
REQ-033 Buffer RAM contents need not be reset.

Configuration
REQ-034 Macro USB_PKTEND_EN: when defined, PKTEND=0 for the single COMMIT cycle if the burst just written was shorter than DEPTH words.
REQ-035 When USB_PKTEND_EN is undefined, PKTEND is constant 1; COMMIT still lasts one cycle and all other timing is identical.

Verification
REQ-036 Reset: rst_n=0 -> SLRD=SLWR=SLOE=PKTEND=1, FIFOADR=00, FD=Z, word_cnt=0, pkt_count=0.
REQ-037 DEPTH=8, EP2 holds 0x1111,0x2222,0x3333,0x4444 -> 4 SLRD pulses, SEL_WR one cycle, 4 SLWR pulses with the same data in order, PKTEND low for 1 cycle (macro on), pkt_count=1.
REQ-038 DEPTH=8, 10 words on EP2 -> 8 reads, 8 writes and no PKTEND; then 2 reads, 2 writes and PKTEND low; pkt_count=2.
REQ-039 FLAGD=0 for 3 cycles after the 2nd write -> SLWR=1 for 3 cycles with FD holding word 3; writing resumes with no word lost or duplicated.
REQ-040 rst_n pulsed low after the 2nd write of 4 -> FD=Z, SLWR=1, IDLE, word_cnt=0 immediately; no further writes.
REQ-041 Macro undefined, REQ-037 stimulus -> identical strobe timing, with PKTEND constantly 1.

Source files
------------

// File: rtl/usb_fifo_loop.sv
// ---------------------------------------------------------------------------
// usb_fifo_loop
//
// Loop-back engine for an FX2 slave FIFO interface. A burst is drained from
// the EP2 OUT FIFO into a local buffer. The same words are then written, in
// order, to the EP6 IN FIFO. One completed read/write loop is one burst.
//
// Optional feature macro: USB_PKTEND_EN
//   defined   : PKTEND pulses low for the COMMIT cycle of any burst shorter
//               than DEPTH words, so the host sees a short packet at once.
//   undefined : PKTEND is tied high. All other timing is unchanged.
//
// Parameters
//   DW       data width of FD and of the buffer words (8 or 16)
//   DEPTH    buffer depth in words (power of two, 4..1024)
//
// Ports
//   CLKOUT     in   FX2 clock; every state change happens on its rising edge
//   rst_n      in   asynchronous active-low reset
//   FLAGA      in   EP2 OUT not-empty (1 = data available)
//   FLAGD      in   EP6 IN not-full (1 = space available)
//   SLRD       out  read strobe, active-low
//   SLWR       out  write strobe, active-low
//   SLOE       out  FD output enable of the FX2, active-low
//   PKTEND     out  packet commit strobe, active-low
//   IFCLK      out  inverted CLKOUT
//   FIFOADR    out  endpoint select (00 = EP2, 10 = EP6)
//   FD         io   FX2 data bus
//   word_cnt   out  buffer occupancy
//   pkt_count  out  completed loops, wraps at 16 bits
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus released, waiting for FLAGA
// SEL_RD | EP2 selected, FX2 asked to drive FD
// READ   | SLRD pulsed each cycle FLAGA=1 and there is room in the buffer
// SEL_WR | EP6 selected, FD left floating for one turnaround cycle
// WRITE  | buffer head driven on FD, SLWR pulsed each cycle FLAGD=1
// COMMIT | one cycle to close the burst (count it, optional PKTEND)
// ---------------------------------------------------------------------------
module usb_fifo_loop #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLKOUT,
  input  logic          rst_n,
  input  logic          FLAGA,
  input  logic          FLAGD,
  output logic          SLRD,
  output logic          SLWR,
  output logic          SLOE,
  output logic          PKTEND,
  output logic          IFCLK,
  output logic [1:0]    FIFOADR,
  inout  wire  [DW-1:0] FD,
  output logic [AW:0]   word_cnt,
  output logic [15:0]   pkt_count
);

  if (!(DW == 8 || DW == 16)) begin : g_bad_dw
    $error("usb_fifo_loop: DW must be 8 or 16");
  end
  if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("usb_fifo_loop: DEPTH must be a power of two in 4..1024");
  end

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] LAST_CNT = FULL_CNT - 1'b1;
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    SEL_RD,
    READ,
    SEL_WR,
    WRITE,
    COMMIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            rd_en;
  logic            wr_en;
  logic            sloe_q;
  logic            fd_oe_q;
  logic [1:0]      fifoadr_q;

  // The strobes have to follow the flags within the same cycle, so they are
  // qualified combinationally. Everything else is registered from state_nxt,
  // so it lines up exactly with the state it belongs to.
  always_comb begin
    rd_en     = (state == READ)  && FLAGA && (word_cnt != FULL_CNT);
    wr_en     = (state == WRITE) && FLAGD && (word_cnt != '0);
    state_nxt = state;
    case (state)
      IDLE:    if (FLAGA) state_nxt = SEL_RD;
      SEL_RD:  state_nxt = READ;
      READ: begin
        if (rd_en) begin
          // The read that fills the buffer closes the loop on the same edge.
          if (word_cnt == LAST_CNT) state_nxt = SEL_WR;
        end else begin
          // An empty burst (flag dropped before the first read) just returns.
          state_nxt = (word_cnt == '0) ? IDLE : SEL_WR;
        end
      end
      SEL_WR:  state_nxt = WRITE;
      WRITE:   if (wr_en && (word_cnt == ONE_CNT)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef USB_PKTEND_EN
  logic burst_full;
  logic pktend_q;
  logic pktend_nxt;

  always_comb begin
    pktend_nxt = !((state_nxt == COMMIT) && !burst_full);
  end
`endif

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      word_cnt  <= '0;
      pkt_count <= '0;
      sloe_q    <= 1'b1;
      fd_oe_q   <= 1'b0;
      fifoadr_q <= 2'b00;
`ifdef USB_PKTEND_EN
      burst_full <= 1'b0;
      pktend_q   <= 1'b1;
`endif
    end else begin
      state <= state_nxt;

      // Reads and writes never overlap, so occupancy moves by at most one.
      if (rd_en) begin
        tail     <= tail + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end else if (wr_en) begin
        head     <= head + 1'b1;
        word_cnt <= word_cnt - 1'b1;
      end

      if (state == COMMIT) pkt_count <= pkt_count + 1'b1;

      sloe_q    <= !((state_nxt == SEL_RD) || (state_nxt == READ));
      fd_oe_q   <= (state_nxt == WRITE) || (state_nxt == COMMIT);
      fifoadr_q <= ((state_nxt == SEL_WR) || (state_nxt == WRITE) ||
                    (state_nxt == COMMIT)) ? 2'b10 : 2'b00;

`ifdef USB_PKTEND_EN
      // Burst length equals occupancy when READ is left, since WRITE always
      // drains the buffer completely before the next READ.
      if ((state == READ) && (state_nxt != READ))
        burst_full <= rd_en || (word_cnt == FULL_CNT);
      pktend_q <= pktend_nxt;
`endif
    end
  end

  // Buffer RAM, deliberately without reset.
  always_ff @(posedge CLKOUT) begin
    if (rd_en) mem[tail] <= FD;
  end

  assign FD      = fd_oe_q ? mem[head] : {DW{1'bz}};
  assign SLRD    = ~rd_en;
  assign SLWR    = ~wr_en;
  assign SLOE    = sloe_q;
  assign FIFOADR = fifoadr_q;
  assign IFCLK   = ~CLKOUT;

`ifdef USB_PKTEND_EN
  assign PKTEND = pktend_q;
`else
  assign PKTEND = 1'b1;
`endif

endmodule
